// File: rtl/ecc_mem_array.sv
// rtl/ecc_mem_array.sv - DEPTH x WIDTH SECDED-protected memory array; background scrubber under ECC_MEM_SCRUB_EN
module ecc_mem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    localparam int AW  = $clog2(DEPTH),
    // Fixed-point iteration of p = clog2(WIDTH+p+1); converges from below in two steps
    localparam int P_A = $clog2(WIDTH + 2),
    localparam int P_B = $clog2(WIDTH + P_A + 1),
    localparam int P   = $clog2(WIDTH + P_B + 1),
    localparam int CW  = WIDTH + P + 1,
    localparam int IW  = $clog2(CW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             inj_en,
    input  logic [IW-1:0]    inj_bit,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             err,
    output logic             uerr,
    output logic [CNT_W-1:0] err_cnt
);

    logic [CW-1:0] mem [DEPTH];

    function automatic logic is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    // Data bits fill non-power-of-two positions in ascending order, then parity, then overall parity in bit 0
    function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] d);
        logic [CW-1:0]    c;
        logic [WIDTH-1:0] dd;
        logic             par;
        c  = '0;
        dd = d;
        for (int j = 1; j < CW; j++) begin
            if (!is_pow2(j)) begin
                c  = c | (CW'(dd[0]) << j);
                dd = dd >> 1;
            end
        end
        for (int i = 0; i < P; i++) begin
            par = 1'b0;
            for (int j = 1; j < CW; j++) begin
                if (((j >> i) & 1) == 1 && j != (1 << i)) par = par ^ 1'(c >> j);
            end
            c = c | (CW'(par) << (1 << i));
        end
        c = c | CW'(^c);
        return c;
    endfunction

    function automatic int syndrome(input logic [CW-1:0] c);
        int s;
        s = 0;
        for (int j = 1; j < CW; j++) begin
            if (1'(c >> j)) s = s ^ j;
        end
        return s;
    endfunction

    // Odd overall parity means one flipped bit; a syndrome beyond the word cannot be repaired
    function automatic logic [CW-1:0] correct(input logic [CW-1:0] c);
        int s;
        s = syndrome(c);
        if ((^c) && s < CW) return c ^ (CW'(1) << s);
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] extract(input logic [CW-1:0] c);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int j = CW - 1; j >= 1; j--) begin
            if (!is_pow2(j)) d = (d << 1) | WIDTH'(1'(c >> j));
        end
        return d;
    endfunction

    logic             sc_wr;
    logic [AW-1:0]    sc_addr;
    logic [CW-1:0]    sc_fix;

`ifdef ECC_MEM_SCRUB_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    sc_state;
    logic [8:0]    sc_ptr;
    logic [CW-1:0] sc_cw;
    logic          sc_busy;

    assign sc_busy = we | re | inj_en;
    assign sc_addr = sc_ptr[AW-1:0];
    assign sc_fix  = correct(sc_cw);
    assign sc_wr   = (sc_state == S_WB) && (^sc_cw) && !(we && addr == sc_addr);

    // Scrub walk: wait for a quiet cycle, fetch mem[ptr], repair single errors, advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_state <= S_IDLE;
            sc_ptr   <= '0;
            sc_cw    <= '0;
        end else begin
            case (sc_state)
                S_IDLE: if (!sc_busy) sc_state <= S_RD;
                S_RD: begin
                    if (sc_busy) begin
                        sc_state <= S_IDLE;
                    end else begin
                        sc_cw    <= mem[sc_addr];
                        sc_state <= S_WB;
                    end
                end
                S_WB: begin
                    sc_ptr   <= (sc_ptr == 9'(DEPTH - 1)) ? '0 : sc_ptr + 9'd1;
                    sc_state <= S_IDLE;
                end
                default: sc_state <= S_IDLE;
            endcase
        end
    end
`else
    assign sc_wr   = 1'b0;
    assign sc_addr = '0;
    assign sc_fix  = '0;
`endif

    // Storage: scrub repair first so a same-cycle user write or injection takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (sc_wr) mem[sc_addr] <= sc_fix;
            if (we) mem[addr] <= encode(wdata);
            else if (inj_en && 32'(inj_bit) < CW) mem[addr] <= mem[addr] ^ (CW'(1) << inj_bit);
        end
    end

    logic          rd_pend;
    logic [CW-1:0] rd_cw;

    // Read capture: samples the pre-write, pre-injection codeword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_cw   <= '0;
        end else begin
            rd_pend <= re;
            if (re) rd_cw <= mem[addr];
        end
    end

    logic             rd_single;
    logic             rd_double;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // Decode classification and saturating counter update
    always_comb begin
        rd_single = ^rd_cw;
        rd_double = !(^rd_cw) && (syndrome(rd_cw) != 0);
        rd_data   = extract(correct(rd_cw));
        cnt_sum   = {1'b0, err_cnt} + {{CNT_W{1'b0}}, rd_pend & rd_single} + {{CNT_W{1'b0}}, sc_wr};
        cnt_next  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Registered read results; rdata holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            uerr    <= 1'b0;
            err_cnt <= '0;
        end else begin
            rvalid  <= rd_pend;
            err     <= rd_pend & rd_single;
            uerr    <= rd_pend & rd_double;
            err_cnt <= cnt_next;
            if (rd_pend) rdata <= rd_data;
        end
    end

endmodule

// File: doc/ecc_mem_array.md
Name: ecc_mem_array

Overview:
- Parametrised successor to the single-bit ECC storage cell: a DEPTH x WIDTH synchronous memory array.
- Each word is stored as a Hamming SECDED codeword, so single-bit upsets are corrected on read and double-bit upsets are flagged.
- Sits between the CPU datapath and register/scratch storage.
- Adds a fault-injection port for verification and a saturating corrected-error counter.

Parameters:
- WIDTH, 8: data bits per word (>= 4).
- DEPTH, 16: number of words (power of two, >= 2).
- CNT_W, 8: width of corrected-error counter.
- Derived localparams, not overridable:
  - AW = clog2(DEPTH).
  - P = smallest p with 2^p >= WIDTH+p+1.
  - CW = WIDTH+P+1: codeword width; WIDTH=8 gives P=4, CW=13.
  - IW = clog2(CW).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- re  in  1  read enable.
- addr  in  AW  word address for write, read and inject.
- wdata  in  WIDTH  write data.
- inj_en  in  1  flip one stored codeword bit at addr.
- inj_bit  in  IW  codeword bit index to flip (0..CW-1).
- rdata  out  WIDTH  corrected read data.
- rvalid  out  1  rdata/err/uerr valid this cycle.
- err  out  1  single-bit error corrected on this read.
- uerr  out  1  double-bit (uncorrectable) error on this read.
- err_cnt  out  CNT_W  saturating count of corrected errors.

Behaviour:
- Codeword layout: Hamming positions 1..CW-1, parity bits at power-of-two positions, data in the remaining positions in ascending order. Bit 0 holds overall even parity over bits 1..CW-1.
- Reset (async, rst_n=0):
  - Every array entry is cleared to all-zero, which is the valid codeword for data 0.
  - rdata=0, rvalid=0, err=0, uerr=0, err_cnt=0.
  - Scrub state (if present) returns to S_IDLE with ptr=0.
  - Reset asserted mid-operation discards any pending read or scrub.
- Write: when we=1 at an edge, mem[addr] <= encode(wdata). Zero latency to storage.
- Read: when re=1 at edge N, the codeword is captured and decoded. rdata/rvalid/err/uerr are registered and valid after edge N+1 (1-cycle latency). rvalid is high for exactly one cycle per read.
- Decode, with syndrome s (P bits) and overall parity q:
  - s=0, q=0: clean, err=0, uerr=0.
  - q=1: single error. Flip bit at position s (s=0 means bit 0). err=1, rdata corrected.
  - s!=0, q=0: double error. uerr=1, rdata = raw data bits uncorrected.
- Read data is corrected only on the output; storage is not written back, except by the scrubber.
- err_cnt increments by 1 on every corrected error (read or scrub) and saturates at 2^CNT_W-1. A uerr does not increment it.
- Simultaneous events, same edge:
  - we and re at the same address: read returns the old contents (read-before-write).
  - we and inj_en: write wins, injection dropped.
  - inj_en alone: mem[addr][inj_bit] ^= 1. An inj_bit >= CW is ignored.
  - re and inj_en: read returns the pre-injection word.
- Idle cycles: outputs other than err_cnt drop to rvalid=0, err=0, uerr=0. rdata holds its last value.

Optional Feature:
- Macro ECC_MEM_SCRUB_EN.
- Defined: a background scrubber with 9-bit ptr (AW bits used).
  - FSM S_IDLE -> S_RD -> S_WB -> S_IDLE.
  - S_IDLE: moves to S_RD on any cycle with we=re=inj_en=0.
  - S_RD: reads mem[ptr]. Any user access in this cycle aborts to S_IDLE with ptr unchanged.
  - S_WB: on a single error, writes the corrected codeword back and increments err_cnt, unless we targets ptr this cycle, in which case the user write wins. ptr then increments, wrapping DEPTH-1 -> 0. On a clean word or uerr, no write.
  - Scrub results never drive rdata/rvalid/err/uerr.
- Undefined: no scrubber logic. Storage changes only via we/inj_en.

Test Plan:
- Reset then re at addr 3: one cycle later rdata=0x00, rvalid=1, err=0, uerr=0, err_cnt=0.
- Write 0xA5 to addr 5, read addr 5: rdata=0xA5, err=0, uerr=0, latency exactly 1 cycle.
- Write 0x3C to addr 2, inject inj_bit=6, read: rdata=0x3C, err=1, uerr=0, err_cnt=1. Repeat with inj_bit=0: err=1, err_cnt=2.
- Write 0xFF to addr 7, inject bits 3 and 9, read: uerr=1, err=0, err_cnt unchanged.
- Write 0x11 to addr 4. Next cycle we=1 (0x22) and re=1 at addr 4: read returns 0x11. A following read returns 0x22. Assert rst_n=0 mid-read: rvalid=0 immediately, array all zero.
- ECC_MEM_SCRUB_EN: inject a single error at addr 9, then idle 2*DEPTH+4 cycles. Reading addr 9 gives err=0, correct data, err_cnt=1. Continuous re traffic keeps ptr frozen.
